display_timing_gen: RTL and testbench

DISPLAY_TIMING_GEN -- requirements
Module: display_timing_gen

---
 rtl/display_timings_pkg.sv | 41 ++++
 rtl/display_timing_gen_if.sv | 28 ++
 rtl/sig_delay.sv | 34 +++
 rtl/display_timing_gen.sv | 108 ++++++++++
 tb/tb_display_timing_gen.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/display_timings_pkg.sv
// rtl/display_timings_pkg.sv - shared video mode constants and timing helpers
package display_timings_pkg;

    // 1280x720 @ 60 Hz, positive syncs
    localparam int TM_720P_H_RES  = 1280;
    localparam int TM_720P_H_FP   = 110;
    localparam int TM_720P_H_SYNC = 40;
    localparam int TM_720P_H_BP   = 220;
    localparam int TM_720P_V_RES  = 720;
    localparam int TM_720P_V_FP   = 5;
    localparam int TM_720P_V_SYNC = 5;
    localparam int TM_720P_V_BP   = 20;
    localparam bit TM_720P_POL    = 1'b1;

    // 640x480 @ 60 Hz, negative syncs
    localparam int TM_640_H_RES   = 640;
    localparam int TM_640_H_FP    = 16;
    localparam int TM_640_H_SYNC  = 96;
    localparam int TM_640_H_BP    = 48;
    localparam int TM_640_V_RES   = 480;
    localparam int TM_640_V_FP    = 10;
    localparam int TM_640_V_SYNC  = 2;
    localparam int TM_640_V_BP    = 33;
    localparam bit TM_640_POL     = 1'b0;

    function automatic int timing_total(input int res, input int fp, input int sync, input int bp);
        return res + fp + sync + bp;
    endfunction

    localparam int TM_720P_H_TOTAL = timing_total(TM_720P_H_RES, TM_720P_H_FP, TM_720P_H_SYNC, TM_720P_H_BP);
    localparam int TM_720P_V_TOTAL = timing_total(TM_720P_V_RES, TM_720P_V_FP, TM_720P_V_SYNC, TM_720P_V_BP);
    localparam int TM_640_H_TOTAL  = timing_total(TM_640_H_RES, TM_640_H_FP, TM_640_H_SYNC, TM_640_H_BP);
    localparam int TM_640_V_TOTAL  = timing_total(TM_640_V_RES, TM_640_V_FP, TM_640_V_SYNC, TM_640_V_BP);

    typedef struct packed {
        logic de;
        logic vs;
        logic hs;
    } sync_t;

endpackage

// File: rtl/display_timing_gen_if.sv
// rtl/display_timing_gen_if.sv - pixel-source and DVI-side signals of the timing generator
interface display_timing_gen_if;
    logic [15:0] o_sx;
    logic [15:0] o_sy;
    logic        o_de;
    logic        o_frame;
    logic        o_line;
    logic [7:0]  i_r;
    logic [7:0]  i_g;
    logic [7:0]  i_b;
    logic        o_dvi_de;
    logic [1:0]  o_dvi_ctrl;
    logic [7:0]  o_dvi_r;
    logic [7:0]  o_dvi_g;
    logic [7:0]  o_dvi_b;

    modport master (
        output o_sx, o_sy, o_de, o_frame, o_line,
        input  i_r, i_g, i_b,
        output o_dvi_de, o_dvi_ctrl, o_dvi_r, o_dvi_g, o_dvi_b
    );

    modport slave (
        input  o_sx, o_sy, o_de, o_frame, o_line,
        output i_r, i_g, i_b,
        input  o_dvi_de, o_dvi_ctrl, o_dvi_r, o_dvi_g, o_dvi_b
    );
endinterface

// File: rtl/sig_delay.sv
// rtl/sig_delay.sv - fixed-depth register pipeline with async reset to a set value
module sig_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic [WIDTH-1:0] o_tap
);
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = i_data;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
        end else begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
        end
    end

    assign o_data = stage_q[DEPTH-1];
    // value about to enter the last stage, so a single-register consumer lines up with o_data
    assign o_tap  = stage_d[DEPTH-1];
endmodule

// File: rtl/display_timing_gen.sv
// rtl/display_timing_gen.sv - raster counters, sync generation and DVI-aligned pixel output
module display_timing_gen
    import display_timings_pkg::*;
#(
    parameter int H_RES    = TM_720P_H_RES,
    parameter int H_FP     = TM_720P_H_FP,
    parameter int H_SYNC   = TM_720P_H_SYNC,
    parameter int H_BP     = TM_720P_H_BP,
    parameter int V_RES    = TM_720P_V_RES,
    parameter int V_FP     = TM_720P_V_FP,
    parameter int V_SYNC   = TM_720P_V_SYNC,
    parameter int V_BP     = TM_720P_V_BP,
    parameter bit H_POL    = TM_720P_POL,
    parameter bit V_POL    = TM_720P_POL,
    parameter int PIPE_DLY = 2
) (
    input  logic                 i_pix_clk,
    input  logic                 i_rst,
    display_timing_gen_if.master bus
);
    localparam int          H_TOTAL = timing_total(H_RES, H_FP, H_SYNC, H_BP);
    localparam int          V_TOTAL = timing_total(V_RES, V_FP, V_SYNC, V_BP);
    localparam logic [15:0] H_LAST  = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST  = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_ACT   = 16'(H_RES);
    localparam logic [15:0] V_ACT   = 16'(V_RES);
    localparam logic [15:0] HS_BEG  = 16'(H_RES + H_FP);
    localparam logic [15:0] HS_END  = 16'(H_RES + H_FP + H_SYNC);
    localparam logic [15:0] VS_BEG  = 16'(V_RES + V_FP);
    localparam logic [15:0] VS_END  = 16'(V_RES + V_FP + V_SYNC);
    localparam sync_t       SYNC_IDLE = '{de: 1'b0, vs: ~V_POL, hs: ~H_POL};

    logic        run_q, run_d;
    logic [15:0] sx_q, sx_d, sy_q, sy_d;
    logic        frame_q, frame_d, line_q, line_d;
    sync_t       sync_q, sync_d;
    logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
    sync_t       dvi, dvi_tap;

    always_comb begin
        run_d = 1'b1;
        sx_d  = sx_q + 16'd1;
        sy_d  = sy_q;
        // first edge after reset presents (0,0) instead of advancing
        if (!run_q) begin
            sx_d = '0;
            sy_d = '0;
        end else if (sx_q == H_LAST) begin
            sx_d = '0;
            sy_d = (sy_q == V_LAST) ? '0 : sy_q + 16'd1;
        end
        sync_d.de = (sx_d < H_ACT) && (sy_d < V_ACT);
        sync_d.hs = (sx_d >= HS_BEG && sx_d < HS_END) ? H_POL : ~H_POL;
        sync_d.vs = (sy_d >= VS_BEG && sy_d < VS_END) ? V_POL : ~V_POL;
        line_d    = (sx_d == '0);
        frame_d   = line_d && (sy_d == '0);
        r_d       = dvi_tap.de ? bus.i_r : '0;
        g_d       = dvi_tap.de ? bus.i_g : '0;
        b_d       = dvi_tap.de ? bus.i_b : '0;
    end

    always_ff @(posedge i_pix_clk or posedge i_rst) begin
        if (i_rst) begin
            run_q   <= 1'b0;
            sx_q    <= '0;
            sy_q    <= '0;
            frame_q <= 1'b0;
            line_q  <= 1'b0;
            sync_q  <= SYNC_IDLE;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            run_q   <= run_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            frame_q <= frame_d;
            line_q  <= line_d;
            sync_q  <= sync_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

    sig_delay #(
        .WIDTH   (3),
        .DEPTH   (PIPE_DLY),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_dly (
        .i_clk  (i_pix_clk),
        .i_rst  (i_rst),
        .i_data (sync_q),
        .o_data (dvi),
        .o_tap  (dvi_tap)
    );

    assign bus.o_sx       = sx_q;
    assign bus.o_sy       = sy_q;
    assign bus.o_de       = sync_q.de;
    assign bus.o_frame    = frame_q;
    assign bus.o_line     = line_q;
    assign bus.o_dvi_de   = dvi.de;
    assign bus.o_dvi_ctrl = {dvi.vs, dvi.hs};
    assign bus.o_dvi_r    = r_q;
    assign bus.o_dvi_g    = g_q;
    assign bus.o_dvi_b    = b_q;
endmodule

// File: tb/tb_display_timing_gen.sv
// tb/tb_display_timing_gen.sv - scoreboard bench for display_timing_gen on a reduced raster
module tb_display_timing_gen;
    localparam int HR = 16, HF = 2, HS = 3, HB = 4;
    localparam int VR = 6,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HR + HF + HS + HB;
    localparam int VT = VR + VF + VS + VB;
    localparam int DA = 3;
    localparam int DB = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    display_timing_gen_if ifa ();
    display_timing_gen_if ifb ();
    display_timing_gen_if ifd ();

    display_timing_gen #(
        .H_RES(HR), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_RES(VR), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b1), .V_POL(1'b1), .PIPE_DLY(DA)
    ) dut_a (.i_pix_clk(clk), .i_rst(rst), .bus(ifa.master));

    display_timing_gen #(
        .H_RES(HR), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_RES(VR), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b0), .V_POL(1'b0), .PIPE_DLY(DB)
    ) dut_b (.i_pix_clk(clk), .i_rst(rst), .bus(ifb.master));

    display_timing_gen dut_d (.i_pix_clk(clk), .i_rst(rst), .bus(ifd.master));

    assign ifd.i_r = 8'h00;
    assign ifd.i_g = 8'h00;
    assign ifd.i_b = 8'h00;

    logic [31:0] pos_a, pos_b, pos_d;
    logic [2:0]  flg_a, flg_b;
    logic [26:0] dvi_a, dvi_b;
    assign pos_a = {ifa.o_sx, ifa.o_sy};
    assign pos_b = {ifb.o_sx, ifb.o_sy};
    assign pos_d = {ifd.o_sx, ifd.o_sy};
    assign flg_a = {ifa.o_de, ifa.o_frame, ifa.o_line};
    assign flg_b = {ifb.o_de, ifb.o_frame, ifb.o_line};
    assign dvi_a = {ifa.o_dvi_de, ifa.o_dvi_ctrl, ifa.o_dvi_r, ifa.o_dvi_g, ifa.o_dvi_b};
    assign dvi_b = {ifb.o_dvi_de, ifb.o_dvi_ctrl, ifb.o_dvi_r, ifb.o_dvi_g, ifb.o_dvi_b};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [23:0] colour(input logic [15:0] x, input logic [15:0] y);
        return {x[7:0], y[7:0], 8'h5A};
    endfunction

    function automatic logic [26:0] exp_dvi(input int x, input int y, input bit pol);
        logic       de, hs, vs;
        logic [7:0] xb, yb;
        de = (x < HR) && (y < VR);
        hs = (x >= HR + HF && x < HR + HF + HS) ? pol : !pol;
        vs = (y >= VR + VF && y < VR + VF + VS) ? pol : !pol;
        xb = 8'(x);
        yb = 8'(y);
        return de ? {1'b1, vs, hs, xb, yb, 8'h5A} : {1'b0, vs, hs, 24'h0};
    endfunction

    // pixel source: colour for the pixel seen D-1 cycles ago
    logic [23:0] hist_a [DA];
    logic [23:0] hist_b [DB];
    always @(posedge clk) begin
        #1;
        for (int i = DA - 1; i > 0; i--) hist_a[i] = hist_a[i-1];
        hist_a[0] = colour(ifa.o_sx, ifa.o_sy);
        {ifa.i_r, ifa.i_g, ifa.i_b} = hist_a[DA-1];
        for (int i = DB - 1; i > 0; i--) hist_b[i] = hist_b[i-1];
        hist_b[0] = colour(ifb.o_sx, ifb.o_sy);
        {ifb.i_r, ifb.i_g, ifb.i_b} = hist_b[DB-1];
    end

    logic [26:0] q_a [$];
    logic [26:0] q_b [$];
    int mx, my, step_no;
    int since_frame, de_cnt, line_cnt, frames_seen;

    task automatic restart();
        mx = 0; my = 0; step_no = 0;
        frames_seen = 0; since_frame = 0; de_cnt = 0; line_cnt = 0;
        q_a.delete();
        q_b.delete();
        for (int i = 0; i < DA; i++) q_a.push_back({1'b0, 2'b00, 24'h0});
        for (int i = 0; i < DB; i++) q_b.push_back({1'b0, 2'b11, 24'h0});
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pos_a"}, pos_a, 32'h0);
        check({tag, "_flg_a"}, {29'h0, flg_a}, 32'h0);
        check({tag, "_dvi_a"}, {5'h0, dvi_a}, {5'h0, 1'b0, 2'b00, 24'h0});
        check({tag, "_pos_b"}, pos_b, 32'h0);
        check({tag, "_flg_b"}, {29'h0, flg_b}, 32'h0);
        check({tag, "_dvi_b"}, {5'h0, dvi_b}, {5'h0, 1'b0, 2'b11, 24'h0});
        check({tag, "_pos_d"}, pos_d, 32'h0);
    endtask

    task automatic step();
        logic [2:0]  eflg;
        logic [26:0] e;
        @(posedge clk);
        #1;
        step_no++;
        eflg = {(mx < HR) && (my < VR), (mx == 0) && (my == 0), mx == 0};
        check("pos_a", pos_a, {16'(mx), 16'(my)});
        check("flg_a", {29'h0, flg_a}, {29'h0, eflg});
        check("pos_b", pos_b, {16'(mx), 16'(my)});
        check("flg_b", {29'h0, flg_b}, {29'h0, eflg});
        q_a.push_back(exp_dvi(mx, my, 1'b1));
        e = q_a.pop_front();
        check("dvi_a", {5'h0, dvi_a}, {5'h0, e});
        q_b.push_back(exp_dvi(mx, my, 1'b0));
        e = q_b.pop_front();
        check("dvi_b", {5'h0, dvi_b}, {5'h0, e});
        if (step_no <= 4) begin
            check("pos_default", pos_d, {16'(step_no - 1), 16'h0});
            check("dvi_de_default", {31'h0, ifd.o_dvi_de}, {31'h0, step_no >= 3});
        end
        if (flg_a[1]) begin
            if (frames_seen == 1) begin
                check("frame_period", since_frame, HT * VT);
                check("frame_de_cnt", de_cnt, HR * VR);
                check("frame_line_cnt", line_cnt, VT);
            end
            frames_seen++;
            since_frame = 0; de_cnt = 0; line_cnt = 0;
        end
        since_frame++;
        de_cnt   += int'(flg_a[2]);
        line_cnt += int'(flg_a[0]);
        mx++;
        if (mx == HT) begin
            mx = 0;
            my = (my == VT - 1) ? 0 : my + 1;
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        restart();
        repeat (2 * HT * VT + 5) step();

        // stop with the raster inside both hsync and vsync
        for (int i = 0; i < 2 * HT * VT && !(mx == HR + HF + 1 && my == VR + VF); i++) step();
        check("reach_mid_reset", {16'(mx), 16'(my)}, {16'(HR + HF + 1), 16'(VR + VF)});
        step();
        rst = 1'b1;
        #1;
        check_reset("async_rst");
        @(posedge clk);
        #1;
        check_reset("held_rst");
        rst = 1'b0;
        restart();
        repeat (HT * VT + HT + 5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
